// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: programmable step-sequence controller.
// Walks a loadable table of {advance, hold} conditions over the monitored
// inputs, one step per clock, with a per-step dwell timeout, optional
// restart-on-miss and sticky pass/fail reporting.
module seq_step_ctrl #(
   parameter int NUM_STEPS = 16,
   parameter int IN_W      = 4,
   parameter int TMO_W     = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [IN_W-1:0]  cfg_adv_mask,
   input  logic [IN_W-1:0]  cfg_adv_val,
   input  logic [IN_W-1:0]  cfg_hold_mask,
   input  logic [IN_W-1:0]  cfg_hold_val,
   input  logic             cfg_last,
   input  logic             start,
   input  logic             abort,
   input  logic             restart_on_miss,
   input  logic [TMO_W-1:0] timeout_limit,
   input  logic [IN_W-1:0]  in_bits,
   output logic             busy,
   output logic [3:0]       step,
   output logic             match_done,
   output logic             fail,
   output logic [3:0]       fail_step,
   output logic [7:0]       miss_count,
   output logic             cfg_err
);

   // Step index width; the table depth is a power of two up to 16.
   localparam int SW = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1;
   localparam logic [SW-1:0] LAST_IDX = SW'(NUM_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   typedef struct packed {
      logic [IN_W-1:0] adv_mask;
      logic [IN_W-1:0] adv_val;
      logic [IN_W-1:0] hold_mask;
      logic [IN_W-1:0] hold_val;
      logic            last;
   } entry_t;

   // Step table; contents are undefined until software loads them.
   entry_t tbl [NUM_STEPS];

   state_t           state_q, state_d;
   logic [SW-1:0]    step_q, step_d;
   logic [TMO_W-1:0] timer_q, timer_d;
   logic [TMO_W-1:0] limit_q, limit_d;
   logic [7:0]       miss_q, miss_d;
   logic             done_q, done_d;
   logic             fail_q, fail_d;
   logic [3:0]       fstep_q, fstep_d;
   logic             busy_q, busy_d;
   logic             cfg_err_q, cfg_err_d;

   entry_t           cur;
   logic             adv_hit;
   logic             hold_hit;
   logic [TMO_W-1:0] timer_inc;
   logic             wr_en;
   logic [SW-1:0]    wr_idx;

   // The table may only change while no run is using it.
   assign wr_en  = cfg_we && (state_q != ST_RUN);
   assign wr_idx = cfg_addr[SW-1:0];

   // Condition evaluation for the step currently being checked.
   assign cur       = tbl[step_q];
   assign adv_hit   = ((in_bits & cur.adv_mask)  == (cur.adv_val  & cur.adv_mask));
   assign hold_hit  = ((in_bits & cur.hold_mask) == (cur.hold_val & cur.hold_mask));
   assign timer_inc = timer_q + TMO_W'(1);

   // Table write port (no reset: contents are software-owned).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tbl[wr_idx] <= '{adv_mask:  cfg_adv_mask,
                          adv_val:   cfg_adv_val,
                          hold_mask: cfg_hold_mask,
                          hold_val:  cfg_hold_val,
                          last:      cfg_last};
      end
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      timer_d   = timer_q;
      limit_d   = limit_q;
      miss_d    = miss_q;
      done_d    = done_q;
      fail_d    = fail_q;
      fstep_d   = fstep_q;
      // A write attempted mid-run is dropped and flagged on the next cycle.
      cfg_err_d = cfg_we && (state_q == ST_RUN);

      if (abort) begin
         // Abort beats everything, including a simultaneous start.
         // fail_step and miss_count are kept for post-mortem reading.
         state_d = ST_IDLE;
         step_d  = '0;
         timer_d = '0;
         done_d  = 1'b0;
         fail_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (start) begin
                  state_d = ST_RUN;
                  step_d  = '0;
                  timer_d = '0;
                  miss_d  = '0;
                  done_d  = 1'b0;
                  fail_d  = 1'b0;
                  limit_d = timeout_limit;
               end
            end
            ST_RUN: begin
               if (adv_hit) begin
                  // Advance has priority over hold.
                  if (cur.last || (step_q == LAST_IDX)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     step_d  = step_q + SW'(1);
                     timer_d = '0;
                  end
               end else if (hold_hit) begin
                  timer_d = timer_inc;
                  if ((limit_q != '0) && (timer_inc == limit_q)) begin
                     state_d = ST_FAIL;
                     fail_d  = 1'b1;
                     fstep_d = 4'(step_q);
                  end
               end else if (restart_on_miss) begin
                  step_d  = '0;
                  timer_d = '0;
                  if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
               end else begin
                  state_d = ST_FAIL;
                  fail_d  = 1'b1;
                  fstep_d = 4'(step_q);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d == ST_RUN);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         step_q    <= '0;
         timer_q   <= '0;
         limit_q   <= '0;
         miss_q    <= '0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
         fstep_q   <= '0;
         busy_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         timer_q   <= timer_d;
         limit_q   <= limit_d;
         miss_q    <= miss_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
         fstep_q   <= fstep_d;
         busy_q    <= busy_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign busy       = busy_q;
   assign step       = 4'(step_q);
   assign match_done = done_q;
   assign fail       = fail_q;
   assign fail_step  = fstep_q;
   assign miss_count = miss_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed self-checking bench for seq_step_ctrl.
module tb_seq_step_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [3:0]  cfg_adv_mask, cfg_adv_val, cfg_hold_mask, cfg_hold_val;
   logic        cfg_last;
   logic        start, abort, restart_on_miss;
   logic [11:0] timeout_limit;
   logic [3:0]  in_bits;
   logic        busy, match_done, fail, cfg_err;
   logic [3:0]  step, fail_step;
   logic [7:0]  miss_count;

   int n_chk = 0;
   int n_err = 0;

   seq_step_ctrl #(.NUM_STEPS(16), .IN_W(4), .TMO_W(12)) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_adv_mask(cfg_adv_mask), .cfg_adv_val(cfg_adv_val),
      .cfg_hold_mask(cfg_hold_mask), .cfg_hold_val(cfg_hold_val),
      .cfg_last(cfg_last), .start(start), .abort(abort),
      .restart_on_miss(restart_on_miss), .timeout_limit(timeout_limit),
      .in_bits(in_bits), .busy(busy), .step(step), .match_done(match_done),
      .fail(fail), .fail_step(fail_step), .miss_count(miss_count),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   // Every comparison goes through here.
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] am, input logic [3:0] av,
                     input logic [3:0] hm, input logic [3:0] hv, input logic l);
      cfg_we = 1'b1; cfg_addr = a;
      cfg_adv_mask = am; cfg_adv_val = av;
      cfg_hold_mask = hm; cfg_hold_val = hv; cfg_last = l;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic load3();
      wr(4'd0, 4'hF, 4'h9, 4'hF, 4'hF, 1'b0);
      wr(4'd1, 4'h4, 4'h4, 4'hF, 4'hF, 1'b0);
      wr(4'd2, 4'hF, 4'h0, 4'hF, 4'hF, 1'b1);
   endtask

   task automatic go();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic drive(input logic [3:0] v);
      in_bits = v; tick();
   endtask

   initial begin
      reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
      cfg_adv_mask = '0; cfg_adv_val = '0; cfg_hold_mask = '0; cfg_hold_val = '0;
      cfg_last = 1'b0; start = 1'b0; abort = 1'b0; restart_on_miss = 1'b0;
      timeout_limit = '0; in_bits = 4'hF;
      tick(); tick();
      reset = 1'b1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_step", 32'(step), 0);
      chk("rst_done", 32'(match_done), 0);
      chk("rst_fail", 32'(fail), 0);
      chk("rst_fstep", 32'(fail_step), 0);
      chk("rst_miss", 32'(miss_count), 0);
      chk("rst_cfgerr", 32'(cfg_err), 0);

      // Exact-match run: 9, 4, 0.
      load3();
      go();
      chk("run_busy", 32'(busy), 1);
      chk("run_step0", 32'(step), 0);
      drive(4'h9); chk("run_step1", 32'(step), 1);
      drive(4'h4); chk("run_step2", 32'(step), 2);
      chk("run_notdone", 32'(match_done), 0);
      drive(4'h0);
      chk("run_done", 32'(match_done), 1);
      chk("run_busy_end", 32'(busy), 0);
      chk("run_fail", 32'(fail), 0);
      chk("run_step_end", 32'(step), 2);

      // Timeout: limit 3, hold-only for 3 cycles.
      wr(4'd0, 4'hF, 4'hF, 4'h1, 4'h0, 1'b0);
      timeout_limit = 12'd3;
      go();
      chk("tmo_done_clr", 32'(match_done), 0);
      drive(4'h0); drive(4'h0);
      chk("tmo_nofail2", 32'(fail), 0);
      chk("tmo_busy2", 32'(busy), 1);
      drive(4'h0);
      chk("tmo_fail", 32'(fail), 1);
      chk("tmo_fstep", 32'(fail_step), 0);
      chk("tmo_done", 32'(match_done), 0);
      chk("tmo_busy", 32'(busy), 0);

      // Miss with restart, then complete.
      timeout_limit = 12'd0;
      load3();
      restart_on_miss = 1'b1;
      go();
      chk("mr_fail_clr", 32'(fail), 0);
      drive(4'h9); drive(4'h2);
      chk("mr_step", 32'(step), 0);
      chk("mr_miss", 32'(miss_count), 1);
      chk("mr_busy", 32'(busy), 1);
      drive(4'h9); drive(4'h4); drive(4'h0);
      chk("mr_done", 32'(match_done), 1);
      chk("mr_miss_keep", 32'(miss_count), 1);

      // Miss without restart fails at step 1.
      restart_on_miss = 1'b0;
      go();
      chk("mf_miss_clr", 32'(miss_count), 0);
      drive(4'h9); drive(4'h2);
      chk("mf_fail", 32'(fail), 1);
      chk("mf_fstep", 32'(fail_step), 1);
      chk("mf_busy", 32'(busy), 0);

      // Abort at step 1.
      go();
      drive(4'h9);
      chk("ab_step1", 32'(step), 1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ab_busy", 32'(busy), 0);
      chk("ab_step", 32'(step), 0);
      chk("ab_done", 32'(match_done), 0);
      chk("ab_fail", 32'(fail), 0);
      chk("ab_fstep_kept", 32'(fail_step), 1);

      // Reset at step 1.
      go();
      drive(4'h9);
      reset = 1'b0; tick(); reset = 1'b1;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_step", 32'(step), 0);
      chk("mrst_fstep", 32'(fail_step), 0);
      chk("mrst_miss", 32'(miss_count), 0);
      chk("mrst_done", 32'(match_done), 0);

      // start and abort together: stay idle.
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("sa_busy", 32'(busy), 0);
      tick();
      chk("sa_busy2", 32'(busy), 0);

      // Config write during RUN is rejected.
      go();
      in_bits = 4'h9;
      cfg_we = 1'b1; cfg_addr = 4'd1; cfg_adv_mask = 4'hF; cfg_adv_val = 4'h0;
      cfg_hold_mask = 4'hF; cfg_hold_val = 4'hF; cfg_last = 1'b0;
      tick(); cfg_we = 1'b0;
      chk("ce_pulse", 32'(cfg_err), 1);
      chk("ce_step", 32'(step), 1);
      drive(4'h4);
      chk("ce_pulse_end", 32'(cfg_err), 0);
      chk("ce_entry_kept", 32'(step), 2);
      drive(4'h0);
      chk("ce_done", 32'(match_done), 1);

      // Write and start in the same cycle: run uses the new entry.
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_adv_mask = 4'hF; cfg_adv_val = 4'h3;
      cfg_hold_mask = 4'hF; cfg_hold_val = 4'hF; cfg_last = 1'b0;
      start = 1'b1; tick(); start = 1'b0; cfg_we = 1'b0;
      chk("ws_cfgerr", 32'(cfg_err), 0);
      drive(4'h3);
      chk("ws_step", 32'(step), 1);
      abort = 1'b1; tick(); abort = 1'b0;

      // Saturation of miss_count.
      restart_on_miss = 1'b1;
      wr(4'd0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      wr(4'd1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
      go();
      for (int i = 0; i < 300; i++) begin
         drive(4'hF); drive(4'h0);
         if (i == 254) chk("sat_255", 32'(miss_count), 255);
      end
      chk("sat_miss", 32'(miss_count), 255);
      chk("sat_busy", 32'(busy), 1);
      chk("sat_step", 32'(step), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
